parity_stream_accum: RTL and testbench

- Parametrised, pipelined parity engine for WIDTH-bit words.
- Accumulates XOR parity across a framed stream (in_last marks the end of a frame).
- Reports one result per frame: parity bit, word count and overflow flag, over a valid/ready interface.
- Sits between a word source and a checker/packer. Replaces the fixed 16-input combinational parity tree.

---
 rtl/parity_stream_accum.sv | 215 +++++++++++++++++++++
 tb/tb_parity_stream_accum.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_accum.sv
// Framed XOR parity accumulator: pipelined per-word reduction tree feeding a frame FSM.
// Optional PARITY_STREAM_CHECK_EN adds exp_parity input and out_err output.
module parity_stream_accum #(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_mode,
`ifdef PARITY_STREAM_CHECK_EN
  input  logic             exp_parity,
  output logic             out_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  localparam int LVL = $clog2(WIDTH);
  localparam int T_VALID = 0;
  localparam int T_LAST  = 1;
  localparam int T_FIRST = 2;
  localparam int T_MODE  = 3;
`ifdef PARITY_STREAM_CHECK_EN
  localparam int T_EXP   = 4;
  localparam int TAG_W   = 5;
`else
  localparam int TAG_W   = 4;
`endif

  typedef enum logic {IDLE, ACCUM} state_t;

  // Valid/ready: a word moves on in_valid & in_ready, a result on out_valid & out_ready.
  // A result held by the consumer freezes every stage (in_ready = en), so nothing is lost or repeated.

  // Applies n pairwise-XOR tree levels; zero padding keeps the total parity unchanged.
  function automatic logic [WIDTH-1:0] xor_levels(input logic [WIDTH-1:0] v, input int n);
    logic [2*WIDTH-1:0] ext;
    logic [WIDTH-1:0]   cur;
    cur = v;
    for (int l = 0; l < LVL; l++) begin
      if (l < n) begin
        ext = {{WIDTH{1'b0}}, cur};
        for (int i = 0; i < WIDTH; i++) cur[i] = ext[2*i] ^ ext[2*i+1];
      end
    end
    return cur;
  endfunction

  // Tree level after which register stage s sits.
  function automatic int bnd(input int s);
    int r;
    if (PIPE_STAGES == 0) r = LVL;
    else r = (s * LVL) / PIPE_STAGES;
    return r;
  endfunction

  logic                            en;
  logic                            first_q, first_d;
  logic [TAG_W-1:0]                in_tag;
  logic [PIPE_STAGES:0][WIDTH-1:0] tap_vec;
  logic [PIPE_STAGES:0][TAG_W-1:0] tap_tag;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_overflow_q, out_overflow_d;
  logic [TAG_W-1:0] t_tag;
  logic             t_par;
  logic             opening;

  assign en       = ~(out_valid_q & ~out_ready);
  assign in_ready = en;

  always_comb begin
    in_tag          = '0;
    in_tag[T_VALID] = in_valid & en;
    in_tag[T_LAST]  = in_last;
    in_tag[T_FIRST] = first_q;
    in_tag[T_MODE]  = odd_mode;
`ifdef PARITY_STREAM_CHECK_EN
    in_tag[T_EXP]   = exp_parity;
`endif
    first_d = (in_valid & en) ? in_last : first_q;
  end

  assign tap_vec[0] = in_data;
  assign tap_tag[0] = in_tag;

  for (genvar s = 1; s <= PIPE_STAGES; s++) begin : g_stage
    localparam int NLEV = bnd(s) - bnd(s - 1);
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    always_comb begin
      vec_d = xor_levels(tap_vec[s-1], NLEV);
      tag_d = tap_tag[s-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vec_q <= '0;
        tag_q <= '0;
      end else if (en) begin
        vec_q <= vec_d;
        tag_q <= tag_d;
      end
    end

    assign tap_vec[s] = vec_q;
    assign tap_tag[s] = tag_q;
  end

  // Remaining levels after the last register collapse into one reduction.
  assign t_tag   = tap_tag[PIPE_STAGES];
  assign t_par   = ^tap_vec[PIPE_STAGES];
  assign opening = (state_q == IDLE) | t_tag[T_FIRST];

`ifdef PARITY_STREAM_CHECK_EN
  logic out_err_q, out_err_d;
`endif

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    mode_d         = mode_q;
    out_valid_d    = out_valid_q & ~out_ready;
    out_parity_d   = out_parity_q;
    out_count_d    = out_count_q;
    out_overflow_d = out_overflow_q;
`ifdef PARITY_STREAM_CHECK_EN
    out_err_d      = out_err_q;
`endif
    if (en && t_tag[T_VALID]) begin
      if (opening) begin
        acc_d  = t_par;
        cnt_d  = CNT_W'(1);
        ovf_d  = 1'b0;
        mode_d = t_tag[T_MODE];
      end else begin
        acc_d = acc_q ^ t_par;
        if (cnt_q == {CNT_W{1'b1}}) ovf_d = 1'b1;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      // Closing word: result loads now and the FSM is free for the next word immediately.
      if (t_tag[T_LAST]) begin
        state_d        = IDLE;
        out_valid_d    = 1'b1;
        out_parity_d   = acc_d ^ mode_d;
        out_count_d    = cnt_d;
        out_overflow_d = ovf_d;
`ifdef PARITY_STREAM_CHECK_EN
        out_err_d      = acc_d ^ mode_d ^ t_tag[T_EXP];
`endif
      end else begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q        <= 1'b1;
      state_q        <= IDLE;
      acc_q          <= 1'b0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      mode_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_parity_q   <= 1'b0;
      out_count_q    <= '0;
      out_overflow_q <= 1'b0;
`ifdef PARITY_STREAM_CHECK_EN
      out_err_q      <= 1'b0;
`endif
    end else begin
      first_q        <= first_d;
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      mode_q         <= mode_d;
      out_valid_q    <= out_valid_d;
      out_parity_q   <= out_parity_d;
      out_count_q    <= out_count_d;
      out_overflow_q <= out_overflow_d;
`ifdef PARITY_STREAM_CHECK_EN
      out_err_q      <= out_err_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_parity   = out_parity_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_overflow_q;
`ifdef PARITY_STREAM_CHECK_EN
  assign out_err      = out_err_q;
`endif

endmodule

// File: tb/tb_parity_stream_accum.sv
// Self-checking bench for parity_stream_accum: directed frames plus randomized framed traffic.
// Frame results are predicted from word lists (popcount parity, saturated length) in a queue.
module tb_parity_stream_accum;
  localparam int WIDTH       = 16;
  localparam int PIPE_STAGES = 2;
  localparam int CNT_W       = 2;
  localparam int MAXC        = (1 << CNT_W) - 1;
  localparam int RES_W       = CNT_W + 3;
`ifdef PARITY_STREAM_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             odd_mode = 1'b0;
  logic             exp_parity = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_parity;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow;
  logic             got_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  bit ready_force = 1'b1;
  bit ready_val = 1'b1;
  logic [RES_W-1:0] exp_q[$];

  parity_stream_accum #(.WIDTH(WIDTH), .PIPE_STAGES(PIPE_STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .odd_mode(odd_mode),
`ifdef PARITY_STREAM_CHECK_EN
    .exp_parity(exp_parity), .out_err(got_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_parity(out_parity),
    .out_count(out_count), .out_overflow(out_overflow)
  );

`ifndef PARITY_STREAM_CHECK_EN
  assign got_err = 1'b0;
`endif

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: random or forced ready, changed just after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input logic l, input logic m, input logic e);
    int w;
    w = 0;
    in_valid = 1'b1; in_data = d; in_last = l; odd_mode = m; exp_parity = e;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    last_acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic p, input int c, input logic o,
                            input logic e, input int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) begin
      chk({name, "_timeout"}, out_valid, 1);
    end else begin
      if (lat > 0) chk({name, "_latency"}, cyc - last_acc_cyc, lat);
      chk({name, "_parity"}, out_parity, p);
      chk({name, "_count"}, out_count, c);
      chk({name, "_overflow"}, out_overflow, o);
      if (CHK_EN) chk({name, "_err"}, got_err, e);
    end
    @(posedge clk);
    #1;
  endtask

  // Reference model: collects each accepted frame and queues its result
  bit   frm_open = 1'b0;
  int   frm_n = 0;
  logic frm_par = 1'b0;
  logic frm_mode = 1'b0;
  int   res_c;
  logic res_p;
  always @(negedge clk) begin
    if (rst) begin
      frm_open = 1'b0;
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      if (!frm_open) begin
        frm_open = 1'b1;
        frm_n = 0;
        frm_par = 1'b0;
        frm_mode = odd_mode;
      end
      frm_n++;
      frm_par = frm_par ^ ($countones(in_data) % 2 == 1);
      if (in_last) begin
        res_c = (frm_n > MAXC) ? MAXC : frm_n;
        res_p = frm_par ^ frm_mode;
        exp_q.push_back({CHK_EN & (res_p ^ exp_parity), frm_n > MAXC, res_c[CNT_W-1:0], res_p});
        frm_open = 1'b0;
      end
    end
  end

  // Compare process: every cycle a result is presented it must match the queue head
  logic [RES_W-1:0] got;
  bit stall_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      got = {got_err, out_overflow, out_count, out_parity};
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (stall_prev) chk("hold_valid", out_valid, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          chk("result", got, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
    end
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int w;
    int len;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_parity", out_parity, 0);
    chk("post_rst_count", out_count, 0);
    chk("post_rst_overflow", out_overflow, 0);
    idle(1);

    send_word(16'h0001, 1'b1, 1'b0, 1'b0);
    expect_res("single", 1'b1, 1, 1'b0, 1'b0, PIPE_STAGES + 1);

    send_word(16'hFFFF, 1'b0, 1'b0, 1'b0);
    send_word(16'h0001, 1'b0, 1'b0, 1'b0);
    send_word(16'h0003, 1'b1, 1'b0, 1'b0);
    expect_res("three_even", 1'b1, 3, 1'b0, 1'b0, PIPE_STAGES + 1);

    send_word(16'hFFFF, 1'b0, 1'b1, 1'b0);
    send_word(16'h0001, 1'b0, 1'b0, 1'b0);
    send_word(16'h0003, 1'b1, 1'b0, 1'b1);
    expect_res("three_odd", 1'b0, 3, 1'b0, 1'b1, PIPE_STAGES + 1);

    for (int i = 0; i < 4; i++) send_word(16'h0000, 1'b0, 1'b0, 1'b0);
    send_word(16'h0000, 1'b1, 1'b0, 1'b0);
    expect_res("sat", 1'b0, 3, 1'b1, 1'b0, PIPE_STAGES + 1);
    send_word(16'h0000, 1'b1, 1'b0, 1'b0);
    expect_res("after_sat", 1'b0, 1, 1'b0, 1'b0, PIPE_STAGES + 1);

    // Backpressure: result held for five cycles while the next word waits
    ready_val = 1'b0;
    idle(2);
    send_word(16'h0003, 1'b1, 1'b0, 1'b0);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1; in_data = 16'h0007; in_last = 1'b1; odd_mode = 1'b0; exp_parity = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_parity", out_parity, 0);
      chk("bp_count", out_count, 1);
      chk("bp_overflow", out_overflow, 0);
    end
    ready_val = 1'b1;
    send_word(16'h0007, 1'b1, 1'b0, 1'b1);
    expect_res("bp_next", 1'b1, 1, 1'b0, 1'b0, PIPE_STAGES + 1);

    // Reset in the middle of a frame discards it
    send_word(16'h00F0, 1'b0, 1'b0, 1'b0);
    send_word(16'h0F00, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_quiet", out_valid, 0);
    end
    idle(1);
    send_word(16'h0007, 1'b1, 1'b0, 1'b0);
    expect_res("post_abort", 1'b1, 1, 1'b0, 1'b1, PIPE_STAGES + 1);

    send_word(16'h0003, 1'b1, 1'b0, 1'b1);
    expect_res("chk_err1", 1'b0, 1, 1'b0, 1'b1, PIPE_STAGES + 1);
    send_word(16'h0003, 1'b1, 1'b0, 1'b0);
    expect_res("chk_err0", 1'b0, 1, 1'b0, 1'b0, PIPE_STAGES + 1);

    // Randomized framed traffic with random consumer stalls
    ready_force = 1'b0;
    for (int f = 0; f < 250; f++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        send_word(WIDTH'($urandom), k == len - 1, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
    end

    ready_force = 1'b1;
    ready_val = 1'b1;
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
